system_mutex_bank: RTL and testbench
====================================

// Module: system_mutex_bank
// PURPOSE
//  Bank of NUM_MUTEX independent hardware mutexes behind one Avalon-MM slave (s1).
//  Next generation of the single system mutex for multi-CPU Nios systems:
//  - parametrised owner/value widths
//  - optional per-slot lease timeout with auto-release
//  - sticky status flags and a release interrupt
//  Sits on the shared system interconnect. CPUs spin on it for shared peripherals/memory.
// PARAMETERS
//  NUM_MUTEX     4    number of mutex slots, 1..64
//  OWNER_W       16   owner ID field width; OWNER_W+VALUE_W <= 32
//  VALUE_W       16   mutex value field width; value==0 means free
//  LEASE_CYCLES  0    lease length in clk cycles; 0 disables timeout
//  LEASE_W       24   lease counter width; LEASE_CYCLES < 2**LEASE_W
//  INIT_OWNER    1    owner field reset value, all slots
//  INIT_VALUE    1    value field reset value, all slots (nonzero = locked at reset)
// PORTS
//  clk            in   1                    system clock
//  reset_n        in   1                    asynchronous active-low reset
//  address        in   clog2(NUM_MUTEX)+1   {slot, sel}; sel=address[0]
//  chipselect     in   1                    slave select
//  read           in   1                    read strobe (data is combinational; no wait states)
//  write          in   1                    write strobe
//  data_from_cpu  in   32                   write data
//  data_to_cpu    out  32                   read data, zero read latency
//  irq            out  1                    level IRQ: OR over slots of (rel_flag & irq_en)
// BEHAVIOUR
//  Register map:
//   sel=0 (MUTEX): [VALUE_W-1:0]=value, [16+OWNER_W-1:16]=owner; unused bits read 0.
//   sel=1 (CSR):   bit0 reset_reg (global), bit1 expired (slot), bit2 rel_flag (slot), bit3 irq_en (slot).
//   Slot index >= NUM_MUTEX: reads 0, writes ignored.
//  Reset values: value=INIT_VALUE, owner=INIT_OWNER, reset_reg=1, expired=0,
//   rel_flag=0, irq_en=0, lease counter=LEASE_CYCLES, irq=0.
//  MUTEX write (cs & write & sel=0):
//   - accepted iff value==0 | owner==data_from_cpu[16+:OWNER_W];
//   - if accepted, value/owner update on the next clk edge; otherwise the write is silently dropped.
//  Lock acquire/renew (accepted write, new value != 0): lease counter reloads to LEASE_CYCLES.
//  Release (value goes nonzero -> 0, by accepted write or by expiry): rel_flag set; owner retained.
//  Lease (LEASE_CYCLES>0 only):
//   - counter decrements once per cycle while value != 0;
//   - when counter==1 with no accepted write to that slot this cycle:
//     next edge value<=0, expired<=1, rel_flag<=1.
//   - Accepted write in the same cycle as expiry: write wins, no expiry, counter reloads.
//   - Counter holds while value==0.
//  CSR write (cs & write & sel=1):
//   - bit0=1 clears reset_reg; it never sets again until reset.
//   - bit1, bit2 are W1C.
//   - bit3 is R/W.
//   - W1C and a same-cycle set event on the same flag: set wins.
//  Reads have no side effects. Slots are fully independent. Simultaneous events on
//   different slots cannot occur (single slave port).
//  irq is registered: it asserts the cycle after rel_flag&irq_en becomes true.
//  reset_n assertion mid-lease: all state returns to reset values asynchronously.
// STRUCTURE
//  Package system_mutex_pkg:
//   - field offsets (VALUE_LSB=0, OWNER_LSB=16);
//   - CSR bit indices (CSR_RESET=0, CSR_EXPIRED=1, CSR_REL=2, CSR_IRQEN=3);
//   - SEL_MUTEX/SEL_CSR constants.
//  Sub-module system_mutex_slot (generate-instanced NUM_MUTEX times):
//   - contains value/owner regs, lease counter, expired/rel_flag/irq_en;
//   - inputs: decoded wr_mutex/wr_csr strobes + write data;
//   - outputs: mutex word, CSR bits, irq_req.
//  Top level holds reset_reg, address decode, read mux and irq OR/register.
// TESTING (NUM_MUTEX=4, LEASE_CYCLES=8 unless noted)
//  1 Reset: read slot0 MUTEX -> 0x00010001; CSR -> 0x1. Write CSR bit0=1, read CSR -> 0x0.
//  2 Ownership: owner 1 writes 0x00010000 (release). CPU 2 writes 0x00020005 -> reads 0x00020005.
//    CPU 3 writes 0x00030007 -> unchanged 0x00020005.
//  3 Lease expiry: slot1 taken 0x00020001, idle 8 cycles -> value 0, owner 2 retained; CSR bits1,2 set.
//    With irq_en=1, irq rises the next cycle. W1C 0x6 -> irq drops.
//  4 Renew race: owner rewrites 0x00020001 exactly in the counter==1 cycle -> no expiry;
//    lock holds 8 more cycles.
//  5 Independence/range: slot3 lock leaves slots 0-2 unchanged.
//    NUM_MUTEX=3: access to slot 3 reads 0; write has no effect.
//  6 Async reset mid-lease (counter=4) -> all slots return to 0x00010001, flags 0, irq 0 immediately.

Source files
------------

// File: rtl/system_mutex_pkg.sv
// rtl/system_mutex_pkg.sv - shared field offsets, CSR bit indices and select codes for the mutex bank
package system_mutex_pkg;

  localparam int VALUE_LSB = 0;
  localparam int OWNER_LSB = 16;

  localparam int CSR_RESET   = 0;
  localparam int CSR_EXPIRED = 1;
  localparam int CSR_REL     = 2;
  localparam int CSR_IRQEN   = 3;

  localparam logic SEL_MUTEX = 1'b0;
  localparam logic SEL_CSR   = 1'b1;

  // Address is {slot, sel}; a single slot still needs the sel bit.
  function automatic int addr_width(input int num_mutex);
    return $clog2(num_mutex) + 1;
  endfunction

endpackage

// File: rtl/system_mutex_bank_if.sv
// rtl/system_mutex_bank_if.sv - Avalon-MM style slave bus of the mutex bank
interface system_mutex_bank_if #(
  parameter int ADDR_W = 3
);

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              read;
  logic              write;
  logic [31:0]       data_from_cpu;
  logic [31:0]       data_to_cpu;
  logic              irq;

  modport master (
    output address, chipselect, read, write, data_from_cpu,
    input  data_to_cpu, irq
  );

  modport slave (
    input  address, chipselect, read, write, data_from_cpu,
    output data_to_cpu, irq
  );

endinterface

// File: rtl/system_mutex_slot.sv
// rtl/system_mutex_slot.sv - one mutex slot: value/owner, lease timer and sticky status flags
module system_mutex_slot
  import system_mutex_pkg::*;
#(
  parameter int OWNER_W      = 16,
  parameter int VALUE_W      = 16,
  parameter int LEASE_CYCLES = 0,
  parameter int LEASE_W      = 24,
  parameter int INIT_OWNER   = 1,
  parameter int INIT_VALUE   = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_mutex,
  input  logic        wr_csr,
  input  logic [31:0] wdata,
  output logic [31:0] mutex_word,
  output logic        expired,
  output logic        rel_flag,
  output logic        irq_en,
  output logic        irq_req
);

  localparam logic [LEASE_W-1:0] LEASE_INIT = LEASE_W'(LEASE_CYCLES);
  localparam logic               LEASE_ON   = (LEASE_CYCLES != 0);

  logic [VALUE_W-1:0] value;
  logic [OWNER_W-1:0] owner;
  logic [LEASE_W-1:0] lease_cnt;

  logic [VALUE_W-1:0] wr_value;
  logic [OWNER_W-1:0] wr_owner;
  logic               locked;
  logic               accept;
  logic               expire;
  logic               release_ev;
  logic               unused_wdata;

  assign wr_value     = wdata[VALUE_LSB +: VALUE_W];
  assign wr_owner     = wdata[OWNER_LSB +: OWNER_W];
  assign unused_wdata = ^wdata;

  assign locked = (value != '0);
  assign accept = wr_mutex && (!locked || (owner == wr_owner));
  // An accepted write in the last lease cycle counts as a renewal, so it suppresses expiry.
  assign expire     = LEASE_ON && locked && (lease_cnt == LEASE_W'(1)) && !accept;
  assign release_ev = (accept && locked && (wr_value == '0)) || expire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value     <= VALUE_W'(INIT_VALUE);
      owner     <= OWNER_W'(INIT_OWNER);
      lease_cnt <= LEASE_INIT;
      expired   <= 1'b0;
      rel_flag  <= 1'b0;
      irq_en    <= 1'b0;
    end else begin
      if (accept) begin
        value <= wr_value;
        owner <= wr_owner;
      end else if (expire) begin
        value <= '0;
      end

      if (accept && (wr_value != '0)) begin
        lease_cnt <= LEASE_INIT;
      end else if (locked && (lease_cnt != '0)) begin
        lease_cnt <= lease_cnt - LEASE_W'(1);
      end

      if (expire) begin
        expired <= 1'b1;
      end else if (wr_csr && wdata[CSR_EXPIRED]) begin
        expired <= 1'b0;
      end

      if (release_ev) begin
        rel_flag <= 1'b1;
      end else if (wr_csr && wdata[CSR_REL]) begin
        rel_flag <= 1'b0;
      end

      if (wr_csr) begin
        irq_en <= wdata[CSR_IRQEN];
      end
    end
  end

  assign irq_req = rel_flag & irq_en;

  always_comb begin
    mutex_word                         = '0;
    mutex_word[VALUE_LSB +: VALUE_W]   = value;
    mutex_word[OWNER_LSB +: OWNER_W]   = owner;
  end

endmodule

// File: rtl/system_mutex_bank.sv
// rtl/system_mutex_bank.sv - bank of hardware mutexes with lease timeout and release interrupt
module system_mutex_bank
  import system_mutex_pkg::*;
#(
  parameter int NUM_MUTEX    = 4,
  parameter int OWNER_W      = 16,
  parameter int VALUE_W      = 16,
  parameter int LEASE_CYCLES = 0,
  parameter int LEASE_W      = 24,
  parameter int INIT_OWNER   = 1,
  parameter int INIT_VALUE   = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  system_mutex_bank_if.slave bus
);

  localparam int ADDR_W = addr_width(NUM_MUTEX);

  logic [ADDR_W-1:0]    slot_idx;
  logic                 sel;
  logic                 in_range;
  logic                 wr_any;
  logic                 reset_reg;
  logic                 irq_q;
  logic [31:0]          rdata;

  logic [31:0]          mutex_word [NUM_MUTEX];
  logic [NUM_MUTEX-1:0] wr_mutex;
  logic [NUM_MUTEX-1:0] wr_csr;
  logic [NUM_MUTEX-1:0] expired;
  logic [NUM_MUTEX-1:0] rel_flag;
  logic [NUM_MUTEX-1:0] irq_en;
  logic [NUM_MUTEX-1:0] irq_req;

  assign slot_idx = bus.address >> 1;
  assign sel      = bus.address[0];
  assign in_range = (slot_idx < ADDR_W'(NUM_MUTEX));
  assign wr_any   = bus.chipselect && bus.write && in_range;

  for (genvar i = 0; i < NUM_MUTEX; i++) begin : g_slot
    assign wr_mutex[i] = wr_any && (sel == SEL_MUTEX) && (slot_idx == ADDR_W'(i));
    assign wr_csr[i]   = wr_any && (sel == SEL_CSR)   && (slot_idx == ADDR_W'(i));

    system_mutex_slot #(
      .OWNER_W      (OWNER_W),
      .VALUE_W      (VALUE_W),
      .LEASE_CYCLES (LEASE_CYCLES),
      .LEASE_W      (LEASE_W),
      .INIT_OWNER   (INIT_OWNER),
      .INIT_VALUE   (INIT_VALUE)
    ) u_slot (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_mutex   (wr_mutex[i]),
      .wr_csr     (wr_csr[i]),
      .wdata      (bus.data_from_cpu),
      .mutex_word (mutex_word[i]),
      .expired    (expired[i]),
      .rel_flag   (rel_flag[i]),
      .irq_en     (irq_en[i]),
      .irq_req    (irq_req[i])
    );
  end

  // reset_reg is a one-shot "bank has been reset" indication shared by all slots.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reset_reg <= 1'b1;
      irq_q     <= 1'b0;
    end else begin
      if (wr_any && (sel == SEL_CSR) && bus.data_from_cpu[CSR_RESET]) begin
        reset_reg <= 1'b0;
      end
      irq_q <= |irq_req;
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_MUTEX; i++) begin
      if (slot_idx == ADDR_W'(i)) begin
        if (sel == SEL_CSR) begin
          rdata[CSR_RESET]   = reset_reg;
          rdata[CSR_EXPIRED] = expired[i];
          rdata[CSR_REL]     = rel_flag[i];
          rdata[CSR_IRQEN]   = irq_en[i];
        end else begin
          rdata = mutex_word[i];
        end
      end
    end
  end

  assign bus.data_to_cpu = (bus.chipselect && bus.read) ? rdata : 32'h0;
  assign bus.irq         = irq_q;

endmodule

// File: tb/tb_system_mutex_bank.sv
// tb/tb_system_mutex_bank.sv - directed table-driven and sequence checks of system_mutex_bank
module tb_system_mutex_bank;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  system_mutex_bank_if #(.ADDR_W(3)) bus4 ();
  system_mutex_bank_if #(.ADDR_W(3)) bus3 ();

  system_mutex_bank #(
    .NUM_MUTEX(4), .OWNER_W(16), .VALUE_W(16), .LEASE_CYCLES(8),
    .LEASE_W(24), .INIT_OWNER(1), .INIT_VALUE(1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus4.slave)
  );

  system_mutex_bank #(
    .NUM_MUTEX(3), .OWNER_W(16), .VALUE_W(16), .LEASE_CYCLES(8),
    .LEASE_W(24), .INIT_OWNER(1), .INIT_VALUE(1)
  ) dut3 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus3.slave)
  );

  typedef struct {
    bit          wr;
    int          slot;
    bit          sel;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    bus4.chipselect = 1'b0; bus4.read = 1'b0; bus4.write = 1'b0;
    bus4.address = '0; bus4.data_from_cpu = '0;
    bus3.chipselect = 1'b0; bus3.read = 1'b0; bus3.write = 1'b0;
    bus3.address = '0; bus3.data_from_cpu = '0;
  endtask

  // Both banks see the same bus traffic; the 3-slot bank mirrors slots 0-2.
  task automatic bus_write(input int slot, input bit sel, input logic [31:0] d);
    @(negedge clk);
    bus4.address = 3'(slot * 2 + int'(sel));
    bus3.address = 3'(slot * 2 + int'(sel));
    bus4.data_from_cpu = d; bus3.data_from_cpu = d;
    bus4.chipselect = 1'b1; bus3.chipselect = 1'b1;
    bus4.write = 1'b1; bus3.write = 1'b1;
    @(posedge clk);
    #1;
    bus_idle();
  endtask

  task automatic bus_read(input int slot, input bit sel, output logic [31:0] d4, output logic [31:0] d3);
    bus4.address = 3'(slot * 2 + int'(sel));
    bus3.address = 3'(slot * 2 + int'(sel));
    bus4.chipselect = 1'b1; bus3.chipselect = 1'b1;
    bus4.read = 1'b1; bus3.read = 1'b1;
    #1;
    d4 = bus4.data_to_cpu;
    d3 = bus3.data_to_cpu;
    bus_idle();
  endtask

  task automatic expect4(input string name, input int slot, input bit sel, input logic [31:0] exp);
    logic [31:0] d4, d3;
    bus_read(slot, sel, d4, d3);
    check(name, d4, exp);
  endtask

  initial begin
    logic [31:0] d4, d3;

    vecs[0]  = '{0, 0, 0, 32'h0001_0001};
    vecs[1]  = '{0, 0, 1, 32'h0000_0001};
    vecs[2]  = '{0, 3, 0, 32'h0001_0001};
    vecs[3]  = '{1, 0, 1, 32'h0000_0001};
    vecs[4]  = '{0, 0, 1, 32'h0000_0000};
    vecs[5]  = '{1, 0, 0, 32'h0001_0000};
    vecs[6]  = '{0, 0, 0, 32'h0001_0000};
    vecs[7]  = '{0, 0, 1, 32'h0000_0004};
    vecs[8]  = '{1, 0, 0, 32'h0002_0005};
    vecs[9]  = '{0, 0, 0, 32'h0002_0005};
    vecs[10] = '{1, 0, 0, 32'h0003_0007};
    vecs[11] = '{0, 0, 0, 32'h0002_0005};
    vecs[12] = '{1, 0, 1, 32'h0000_0004};
    vecs[13] = '{0, 0, 1, 32'h0000_0000};

    bus_idle();
    repeat (2) @(negedge clk);
    #1;
    check("reset_irq", {31'b0, bus4.irq}, 32'h0);
    reset_n = 1'b1;

    // Reset state, ownership and release: all within the initial 8-cycle lease.
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) begin
        bus_write(vecs[i].slot, vecs[i].sel, vecs[i].data);
      end else begin
        bus_read(vecs[i].slot, vecs[i].sel, d4, d3);
        check($sformatf("vec%0d", i), d4, vecs[i].data);
      end
    end

    // Reset-time locks and slot0's owner-2 lock auto-expire; owners are retained.
    repeat (12) @(posedge clk);
    #1;
    expect4("init_expire_s3_mutex", 3, 0, 32'h0001_0000);
    expect4("init_expire_s3_csr",   3, 1, 32'h0000_0006);
    expect4("s0_expire_mutex",      0, 0, 32'h0002_0000);
    expect4("s0_expire_csr",        0, 1, 32'h0000_0006);
    check("irq_disabled", {31'b0, bus4.irq}, 32'h0);
    for (int s = 0; s < 4; s++) bus_write(s, 1, 32'h6);
    expect4("w1c_s1_csr", 1, 1, 32'h0);

    // Lease expiry on slot1 with interrupt.
    bus_write(1, 1, 32'h8);
    bus_write(1, 0, 32'h0002_0001);
    repeat (7) @(posedge clk);
    #1;
    expect4("lease_hold_s1", 1, 0, 32'h0002_0001);
    @(posedge clk);
    #1;
    expect4("lease_expired_s1", 1, 0, 32'h0002_0000);
    expect4("lease_csr_s1",     1, 1, 32'h0000_000E);
    check("irq_not_yet", {31'b0, bus4.irq}, 32'h0);
    @(posedge clk);
    #1;
    check("irq_rise", {31'b0, bus4.irq}, 32'h1);
    bus_write(1, 1, 32'h6);
    @(posedge clk);
    #1;
    check("irq_drop", {31'b0, bus4.irq}, 32'h0);
    expect4("w1c_csr_s1", 1, 1, 32'h0);

    // Renewal in the counter==1 cycle beats expiry.
    bus_write(2, 0, 32'h0002_0001);
    repeat (7) @(posedge clk);
    bus_write(2, 0, 32'h0002_0001);
    expect4("renew_value", 2, 0, 32'h0002_0001);
    expect4("renew_csr",   2, 1, 32'h0);
    repeat (7) @(posedge clk);
    #1;
    expect4("renew_hold", 2, 0, 32'h0002_0001);
    @(posedge clk);
    #1;
    expect4("renew_expire",     2, 0, 32'h0002_0000);
    expect4("renew_expire_csr", 2, 1, 32'h0000_0006);

    // Raise irq via an explicit release on slot0, then lock slot3.
    bus_write(0, 1, 32'h8);
    bus_write(0, 0, 32'h0002_0003);
    bus_write(0, 0, 32'h0002_0000);
    bus_write(3, 0, 32'h0005_0009);
    expect4("indep_s0", 0, 0, 32'h0002_0000);
    expect4("indep_s1", 1, 0, 32'h0002_0000);
    expect4("indep_s2", 2, 0, 32'h0002_0000);
    expect4("indep_s3", 3, 0, 32'h0005_0009);
    bus_read(3, 0, d4, d3);
    check("range_mutex_rd", d3, 32'h0);
    bus_read(3, 1, d4, d3);
    check("range_csr_rd", d3, 32'h0);
    bus_read(2, 0, d4, d3);
    check("range_s2_untouched", d3, 32'h0002_0000);
    check("release_irq", {31'b0, bus4.irq}, 32'h1);

    // Asynchronous reset while slot3's counter is at 4.
    repeat (4) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("areset_irq", {31'b0, bus4.irq}, 32'h0);
    check("areset_irq3", {31'b0, bus3.irq}, 32'h0);
    for (int s = 0; s < 4; s++) begin
      expect4($sformatf("areset_mutex_s%0d", s), s, 0, 32'h0001_0001);
    end
    expect4("areset_csr_s0", 0, 1, 32'h1);
    expect4("areset_csr_s3", 3, 1, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
